// File: rtl/flo_rr_sched.sv
// Round-robin issue scheduler: find-lowest-one pick over a rotated
// request mask, registered valid/ready grant, in-flight scoreboard.
module flo_rr_sched #(
  parameter int N  = 24,
  parameter int IW = 7
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  rel_i,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic [N-1:0]  gnt_oh_o,
  input  logic          gnt_ready_i,
  output logic [N-1:0]  inflight_o,
  output logic [IW-1:0] busy_cnt_o,
  output logic          full_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  localparam logic [IW-1:0] PTR_RST = IW'(N - 1);
  localparam logic [IW-1:0] CNT_MAX = IW'(N);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] cnt_q;
  logic [N-1:0]  infl_q;

  logic [N-1:0]  elig;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  hi;
  logic [N-1:0]  set_vec;
  logic [N-1:0]  rel_eff;
  logic          hi_any;
  logic          pick_ok;
  logic          load;
  logic [IW-1:0] pick;
  logic [IW-1:0] rel_cnt;
  logic [IW-1:0] cnt_nxt;

  function automatic logic [IW-1:0] ffo(
    input logic [N-1:0] v
  );
    logic [IW-1:0] r;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (v[k]) r = IW'(k);
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] popc(
    input logic [N-1:0] v
  );
    logic [IW-1:0] c;
    c = '0;
    for (int k = 0; k < N; k++) begin
      c = c + IW'(v[k]);
    end
    return c;
  endfunction

  // Selection sees the pre-update scoreboard
  always_comb begin
    elig    = req_i & ~infl_q;
    hi_mask = '0;
    for (int k = 0; k < N; k++) begin
      hi_mask[k] = (IW'(k) > ptr);
    end
    hi      = elig & hi_mask;
    hi_any  = |hi;
    pick_ok = |elig;
    pick    = hi_any ? ffo(hi) : ffo(elig);
    load    = pick_ok &&
              ((state == EMPTY) || gnt_ready_i);
  end

  always_comb begin
    set_vec = '0;
    for (int k = 0; k < N; k++) begin
      set_vec[k] = load && (pick == IW'(k));
    end
    rel_eff = rel_i & infl_q;
    rel_cnt = popc(rel_eff);
    cnt_nxt = cnt_q + IW'(load) - rel_cnt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= EMPTY;
      idx_q  <= '0;
      ptr    <= PTR_RST;
      infl_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      state  <= EMPTY;
      idx_q  <= '0;
      ptr    <= PTR_RST;
      infl_q <= '0;
      cnt_q  <= '0;
    end else begin
      infl_q <= (infl_q & ~rel_i) | set_vec;
      cnt_q  <= cnt_nxt;
      unique case (state)
        EMPTY: begin
          if (load) begin
            idx_q <= pick;
            ptr   <= pick;
            state <= HELD;
          end
        end
        HELD: begin
          if (load) begin
            idx_q <= pick;
            ptr   <= pick;
          end else if (gnt_ready_i) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_comb begin
    gnt_oh_o = '0;
    for (int k = 0; k < N; k++) begin
      gnt_oh_o[k] = (state == HELD) &&
                    (idx_q == IW'(k));
    end
  end

  assign gnt_valid_o = (state == HELD);
  assign gnt_idx_o   = idx_q;
  assign inflight_o  = infl_q;
  assign busy_cnt_o  = cnt_q;
  assign full_o      = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_flo_rr_sched.sv
// Directed bench for flo_rr_sched (N=24): reset, round-robin order,
// backpressure, full, simultaneous events, flush.
module tb_flo_rr_sched;

  localparam int N  = 24;
  localparam int IW = 7;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [N-1:0]  req;
  logic [N-1:0]  rel;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  gnt_oh;
  logic          gnt_ready;
  logic [N-1:0]  inflight;
  logic [IW-1:0] busy_cnt;
  logic          full;

  int n_chk;
  int n_fail;

  flo_rr_sched #(.N(N), .IW(IW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .req_i       (req),
    .rel_i       (rel),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .gnt_oh_o    (gnt_oh),
    .gnt_ready_i (gnt_ready),
    .inflight_o  (inflight),
    .busy_cnt_o  (busy_cnt),
    .full_o      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    req   = '0;
    rel   = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  int rr_exp [5] = '{0, 4, 23, 0, 4};

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    req       = N'($urandom);
    rel       = N'($urandom);
    gnt_ready = 1'($urandom);

    // reset with random inputs
    tick();
    check("rst_valid", 64'(gnt_valid), 64'd0);
    check("rst_idx",   64'(gnt_idx),   64'd0);
    check("rst_oh",    64'(gnt_oh),    64'd0);
    check("rst_infl",  64'(inflight),  64'd0);
    check("rst_cnt",   64'(busy_cnt),  64'd0);
    check("rst_full",  64'(full),      64'd0);

    rst_n     = 1'b1;
    req       = 24'h000001;
    rel       = '0;
    gnt_ready = 1'b0;
    tick();
    check("post_rst_valid", 64'(gnt_valid), 64'd1);
    check("post_rst_idx",   64'(gnt_idx),   64'd0);
    check("post_rst_infl",  64'(inflight),  64'h1);
    check("post_rst_oh",    64'(gnt_oh),    64'h1);

    // round-robin order with wrap 23 -> 0
    do_flush();
    req       = 24'h800011;
    gnt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rr_idx%0d", i),
            64'(gnt_idx), 64'(rr_exp[i]));
      check($sformatf("rr_oh%0d", i),
            64'(gnt_oh), 64'(1) << rr_exp[i]);
      rel = N'(1) << rr_exp[i];
    end

    // backpressure
    do_flush();
    req       = 24'h00000F;
    gnt_ready = 1'b0;
    tick();
    check("bp_first", 64'(gnt_idx), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_idx%0d", i),
            64'(gnt_idx), 64'd0);
      check($sformatf("bp_hold_cnt%0d", i),
            64'(busy_cnt), 64'd1);
    end
    gnt_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("bp_idx%0d", i),
            64'(gnt_idx), 64'(i));
      check($sformatf("bp_cnt%0d", i),
            64'(busy_cnt), 64'(i + 1));
    end
    tick();
    check("bp_drop", 64'(gnt_valid), 64'd0);

    // full
    do_flush();
    req       = '1;
    gnt_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      tick();
      check($sformatf("full_idx%0d", i),
            64'(gnt_idx), 64'(i));
    end
    check("full_cnt",  64'(busy_cnt), 64'd24);
    check("full_flag", 64'(full),     64'd1);
    tick();
    check("full_drop", 64'(gnt_valid), 64'd0);
    check("full_keep", 64'(full),      64'd1);
    rel = 24'h000200;
    tick();
    rel = '0;
    check("full_rel_valid", 64'(gnt_valid), 64'd0);
    check("full_rel_cnt",   64'(busy_cnt),  64'd23);
    check("full_rel_flag",  64'(full),      64'd0);
    tick();
    check("full_g9_valid", 64'(gnt_valid), 64'd1);
    check("full_g9_idx",   64'(gnt_idx),   64'd9);
    check("full_g9_cnt",   64'(busy_cnt),  64'd24);

    // simultaneous release and request of bit 3
    do_flush();
    req       = 24'h000008;
    gnt_ready = 1'b1;
    tick();
    check("sim_g3", 64'(gnt_idx), 64'd3);
    rel = 24'h000008;
    tick();
    rel = '0;
    check("sim_none_valid", 64'(gnt_valid), 64'd0);
    check("sim_none_cnt",   64'(busy_cnt),  64'd0);
    tick();
    check("sim_again_valid", 64'(gnt_valid), 64'd1);
    check("sim_again_idx",   64'(gnt_idx),   64'd3);
    req       = '0;
    gnt_ready = 1'b0;
    rel       = 24'h000010;
    tick();
    rel = '0;
    check("spur_cnt",  64'(busy_cnt), 64'd1);
    check("spur_infl", 64'(inflight), 64'h8);

    // flush while held with 5 in flight
    do_flush();
    req       = 24'h00001F;
    gnt_ready = 1'b1;
    repeat (5) tick();
    check("fl_pre_cnt",   64'(busy_cnt),  64'd5);
    check("fl_pre_valid", 64'(gnt_valid), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", 64'(gnt_valid), 64'd0);
    check("fl_cnt",   64'(busy_cnt),  64'd0);
    check("fl_infl",  64'(inflight),  64'd0);
    req = '1;
    tick();
    check("fl_next_idx",   64'(gnt_idx),   64'd0);
    check("fl_next_valid", 64'(gnt_valid), 64'd1);

    // asynchronous reset mid-grant
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(gnt_valid), 64'd0);
    check("arst_cnt",   64'(busy_cnt),  64'd0);
    check("arst_infl",  64'(inflight),  64'd0);
    rst_n = 1'b1;
    req   = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flo_rr_sched.md
# flo_rr_sched

Round-robin issue scheduler for a bank of up to 96 requesters. Each cycle it picks the next requester after the last-granted index using a find-lowest-one priority encode over a rotated request mask. It presents the pick as a registered valid/ready grant and tracks granted-but-unreleased entries in an in-flight scoreboard. It sits between the issue queue's ready vector and a single shared execution port.

## Interface

**Parameters**
- `N`, default 24: number of requesters. Legal range 2..96.
- `IW`, default 7: index width. Must satisfy 2^IW > N.

**Ports** (name, direction, width, meaning)
- `clk_i`, in, 1: clock. All state changes on the rising edge.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `flush_i`, in, 1: synchronous clear of the grant output, pointer, scoreboard and count.
- `req_i`, in, N: request vector. Bit k means requester k is ready to issue.
- `rel_i`, in, N: release pulses. Bit k clears in-flight bit k.
- `gnt_valid_o`, out, 1: grant valid.
- `gnt_idx_o`, out, IW: granted requester index.
- `gnt_oh_o`, out, N: one-hot form of `gnt_idx_o`. All zero when `gnt_valid_o` = 0.
- `gnt_ready_i`, in, 1: consumer accepts the grant.
- `inflight_o`, out, N: scoreboard of granted, unreleased entries.
- `busy_cnt_o`, out, IW: population count of `inflight_o`.
- `full_o`, out, 1: asserted when `busy_cnt_o` == N.

## Operation

**Internal state**
- `ptr`: last-granted index.
- `inflight`: N-bit scoreboard.
- `cnt`: in-flight count.
- Output registers: `gnt_valid_o`, `gnt_idx_o`.

**Candidate selection**
- `elig` = `req_i` & ~`inflight`.
- `hi` = `elig` masked to bits strictly above `ptr`.
- If `hi` ≠ 0, pick = lowest set bit of `hi`. Otherwise pick = lowest set bit of `elig`.
- If `elig` = 0, there is no pick.

**Two-state FSM**
- EMPTY (`gnt_valid_o` = 0): if a pick exists, load `gnt_idx_o` = pick, set `gnt_valid_o`, set `inflight[pick]`, set `ptr` = pick, and go to HELD. Otherwise stay.
- HELD (`gnt_valid_o` = 1):
  - If `gnt_ready_i` = 0: outputs hold stable and no new pick is made.
  - If `gnt_ready_i` = 1 and a pick exists: load the new pick in the same cycle (back-to-back issue) and stay in HELD.
  - If `gnt_ready_i` = 1 and no pick exists: clear `gnt_valid_o` and go to EMPTY.
- The in-flight bit is set when the grant is loaded, not when it is accepted. An entry therefore cannot be selected twice while it is held.

**Scoreboard update**
- Next `inflight` = (`inflight` & ~`rel_i`) | setbit(pick, if loaded).
- Selection uses the pre-update `inflight`. A bit released in cycle t is eligible in cycle t+1.
- `rel_i` on a bit that is not in flight is ignored and does not change `cnt`.
- `cnt` next = `cnt` + (loaded ? 1 : 0) − popcount(`rel_i` & `inflight`).

**Boundary rules**
- `ptr` = N−1 makes `hi` empty, so the search wraps to bit 0.
- While `full_o` = 1 there is no pick and `gnt_valid_o` drops after the current grant is accepted.
- `flush_i` = 1: next cycle `gnt_valid_o` = 0, `inflight` = 0, `cnt` = 0, `ptr` = N−1. No pick is loaded in the flush cycle. `flush_i` has priority over everything except reset.
- Reset asserted mid-grant: all state goes immediately to its reset values. Any held grant is lost, and the consumer must not treat it as accepted.

## Timing

**Reset values**
- `gnt_valid_o` = 0, `gnt_idx_o` = 0, `gnt_oh_o` = 0
- `inflight_o` = 0, `busy_cnt_o` = 0, `full_o` = 0
- `ptr` = N−1

**Latency and throughput**
- Request visible in cycle t → grant valid at edge t+1 (one cycle, registered).
- One grant per cycle while `gnt_ready_i` is held at 1 and eligible requests exist.
- Release in cycle t → entry grantable at the t+1 evaluation → grant output at t+2.

**Output rules**
- All outputs are registered or decoded from registers. There are no combinational paths from inputs to outputs.
- Valid/ready rule: while `gnt_valid_o` = 1 and `gnt_ready_i` = 0, `gnt_idx_o` and `gnt_oh_o` are stable.

## Test plan

- **Reset:** `rst_ni` low with random inputs → all outputs zero. After release with `req_i` = 0x000001, next cycle `gnt_idx_o` = 0 and `inflight_o` = 0x000001.
- **Round-robin order:** N=24, `req_i` = 0x800011 held, `gnt_ready_i` = 1, release each grant one cycle after issue → grant sequence 0, 4, 23, 0, 4. The wrap from 23 to 0 is covered.
- **Backpressure:** `gnt_ready_i` = 0 for 5 cycles with `req_i` = 0x00000F → `gnt_idx_o` stays 0 and `busy_cnt_o` stays 1. On ready, grants 1, 2, 3 follow on consecutive cycles.
- **Full:** all 24 requests granted with no release → `full_o` = 1 and `busy_cnt_o` = 24, then `gnt_valid_o` drops. Pulse `rel_i` = 0x000200 → next grant index 9 appears two cycles later.
- **Simultaneous events:** release bit 3 in the same cycle bit 3 is the only request → no grant that cycle, grant 3 one cycle later. Spurious release of a non-in-flight bit → `busy_cnt_o` unchanged.
- **Flush:** `flush_i` pulsed while HELD with 5 entries in flight → next cycle `gnt_valid_o` = 0 and `busy_cnt_o` = 0. With all requests set, the next grant index is 0.
